instr_queue: RTL
================

# instr_queue

Parametrised instruction queue: successor to the single-entry instruction register in the control unit. It buffers up to DEPTH fetched instruction words between memory fetch and decode, using valid/ready handshakes on both sides. It presents the oldest word to the decoder and supports a single-cycle flush for branches and jumps. Sits between the instruction-memory read port and the control-unit FSM.

## Interface
Parameters:
- WIDTH, 16, instruction word width in bits (≥1)
- DEPTH, 4, number of queue entries (power of two, ≥2)

Ports:
- Clock  in  1  single clock; all state updates on posedge Clock
- Reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all queued entries
- in_valid  in  1  fetch side presents a word
- in_ready  out  1  queue can accept a word this cycle
- in_data  in  WIDTH  fetched instruction word
- out_valid  out  1  `instruction` holds a valid word
- out_ready  in  1  decoder consumes the word this cycle
- instruction  out  WIDTH  oldest queued word (head)
- count  out  $clog2(DEPTH+1)  number of stored entries

## Operation
- Storage: circular buffer of DEPTH×WIDTH, write pointer wr_ptr, read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
- Push occurs when in_valid && in_ready: mem[wr_ptr] ← in_data, wr_ptr+1.
- Pop occurs when out_valid && out_ready: rd_ptr+1.
- in_ready = (count < DEPTH). A full queue does not accept a write, even in a cycle that also pops.
- out_valid = (count != 0). instruction = mem[rd_ptr] when out_valid, otherwise all zeros.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged (head and tail both advance).
- Priority: Reset > flush > push/pop.
- flush: count, wr_ptr and rd_ptr go to 0. Any push or pop in the same cycle is ignored. The fetch side sees in_ready per the pre-flush count, but a word presented in the flush cycle is dropped.
- Reset: same as flush. Memory contents are not cleared. After Reset the outputs are count=0, out_valid=0, in_ready=1, instruction=0.
- Pushing while full and popping while empty cannot occur by construction, because the handshake gates them. in_valid or out_ready asserted in those states has no effect.

## Timing
- Latency without bypass: a word accepted at edge N is visible on instruction with out_valid=1 after edge N (cycle N+1).
- in_ready, out_valid, count and instruction are functions of registered state only. There is no combinational in→out path unless bypass is compiled in.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Reset or flush asserted mid-stream takes effect at the next edge. In the following cycle the queue is empty and ready.

## Configuration
- IQ_BYPASS_EN defined:
  - When count==0 and in_valid=1, out_valid=1 and instruction=in_data combinationally.
  - If out_ready=1 in that cycle, the word is consumed directly. It is not written, and count stays 0.
  - If out_ready=0, the word is pushed normally.
  - in_ready is unchanged.
  - Bypass is suppressed during flush and Reset.
- IQ_BYPASS_EN undefined:
  - No bypass. Minimum accept-to-present latency is 1 cycle, as above.

## Test plan
- Reset: assert Reset 2 cycles with in_valid=1, in_data=16'hFFFF → after release count=0, out_valid=0, in_ready=1, instruction=16'h0000.
- Fill/drain, DEPTH=4, out_ready=0:
  - Push 16'h1001..16'h1004 → count=4, in_ready=0, instruction=16'h1001.
  - A 5th push of 16'h1005 is refused.
  - Then out_ready=1 for 4 cycles → outputs 1001,1002,1003,1004 in order, then out_valid=0.
- Wrap and simultaneous push/pop:
  - Stream 10 words 16'h2000..16'h2009 with in_valid=out_ready=1 continuously.
  - Required: all emerge in order, count stays at 1 in steady state, and pointers wrap with no loss.
- Flush priority:
  - With count=3, assert flush together with in_valid=1 (16'hABCD) and out_ready=1 → next cycle count=0, out_valid=0.
  - 16'hABCD is never output.
  - The next push of 16'h0042 appears as head one cycle later.
- Bypass (IQ_BYPASS_EN):
  - Empty queue, in_valid=out_ready=1, in_data=16'h5A5A → same-cycle out_valid=1, instruction=16'h5A5A, count stays 0.
  - Without the macro, out_valid=0 in that cycle and the word appears the next cycle with count=1.
- Width/depth generality: WIDTH=32, DEPTH=8 → 8 pushes accepted, 9th refused, count reaches 8 (4-bit), ordered drain matches the pushes.

Source files
------------

// File: rtl/instr_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | instr_queue_if                                                         |
// | Fetch-side and decode-side handshake bundle for instr_queue.           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface instr_queue_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] instruction;
  logic [CW-1:0]    count;

  // master: the fetch/decode environment; slave: the queue itself
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, instruction, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, instruction, count
  );
endinterface
`default_nettype wire

// File: rtl/instr_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | instr_queue                                                            |
// | Circular instruction buffer between fetch and decode with flush.       |
// | Option macro: IQ_BYPASS_EN (empty-queue combinational bypass).         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module instr_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  wire              Clock,
  input  wire              Reset,
  instr_queue_if.slave     bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_empty;
  logic             w_in_ready;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_instruction;
  logic             w_push;
  logic             w_pop;

  assign w_empty    = (r_count == '0);
  assign w_in_ready = (r_count < C_DEPTH);

`ifdef IQ_BYPASS_EN
  logic w_bypass;
  logic w_bypass_take;

  // An empty queue forwards the incoming word; if decode takes it, it is never stored.
  assign w_bypass      = w_empty && bus.in_valid && !bus.flush && !Reset;
  assign w_bypass_take = w_bypass && bus.out_ready;

  always_comb begin
    w_out_valid   = 1'b0;
    w_instruction = '0;
    if (!w_empty) begin
      w_out_valid   = 1'b1;
      w_instruction = r_mem[r_rd_ptr];
    end else if (w_bypass) begin
      w_out_valid   = 1'b1;
      w_instruction = bus.in_data;
    end
  end

  assign w_push = bus.in_valid && w_in_ready && !w_bypass_take;
  assign w_pop  = !w_empty && bus.out_ready;
`else
  always_comb begin
    w_out_valid   = 1'b0;
    w_instruction = '0;
    if (!w_empty) begin
      w_out_valid   = 1'b1;
      w_instruction = r_mem[r_rd_ptr];
    end
  end

  assign w_push = bus.in_valid && w_in_ready;
  assign w_pop  = w_out_valid && bus.out_ready;
`endif

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.instruction = w_instruction;
  assign bus.count       = r_count;

  // Storage is deliberately not reset; count gates every read of it.
  always_ff @(posedge Clock) begin
    if (!Reset && !bus.flush && w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire
